// File: rtl/mem_io_responder.sv
// Memory/IO responder: word RAM, LED register, 8N1 UART transmitter and a free-running
// cycle counter, all behind one strobe/mask processor bus with a registered read port.
module mem_io_responder #(
  parameter int RAM_WORDS = 256,
  parameter int BAUD_DIV  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [4:0]  LEDS,
  output logic        TXD,
  output logic        uart_busy,
  output logic [1:0]  o_uart_state
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Bus handshake: there is no valid/ready pair. A read is a one-cycle mem_rstrb, a write
  // is any nonzero mem_wmask; both are always accepted on the edge they are presented.
  // Read data is valid the cycle after the strobe edge and holds until the next strobe.
  logic          w_is_io;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_io_reg;
  logic          w_io_wr_ok;
  logic          w_uart_accept;
  logic [31:0]   w_io_rdata;
  logic          w_baud_tick;
  logic          w_unused_addr;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_rdata;
  logic [4:0]    r_leds;
  logic [31:0]   r_cycles;

  uart_state_t   r_state;
  uart_state_t   w_state_next;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_txd;

  assign w_is_io       = mem_addr[22];
  assign w_ram_idx     = mem_addr[AW+1:2];
  assign w_io_reg      = mem_addr[3:2];
  assign w_io_wr_ok    = resetn && w_is_io && mem_wmask[0];
  assign w_uart_accept = w_io_wr_ok && (w_io_reg == 2'd1) && (r_state == S_IDLE);
  assign w_baud_tick   = (r_baud_cnt == BAUD_LAST);
  assign w_unused_addr = ^{mem_addr[31:23], mem_addr[21:AW+2], mem_addr[1:0]};

  // RAM has no reset so its contents survive resetn; writes are still blocked during reset.
  always_ff @(posedge clk) begin
    if (resetn && !w_is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) r_ram[w_ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // CYCLES reads the value the counter takes at the strobe edge, hence the +1.
  always_comb begin
    w_io_rdata = 32'd0;
    case (w_io_reg)
      2'd0:    w_io_rdata = {27'd0, r_leds};
      2'd1:    w_io_rdata = {31'd0, uart_busy};
      2'd2:    w_io_rdata = r_cycles + 32'd1;
      default: w_io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata  <= 32'd0;
      r_leds   <= 5'd0;
      r_cycles <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (mem_rstrb) r_rdata <= w_is_io ? w_io_rdata : r_ram[w_ram_idx];
      if (w_io_wr_ok && (w_io_reg == 2'd0)) r_leds <= mem_wdata[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_txd        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_uart_accept) w_state_next = S_START;
      end
      S_START: begin
        w_txd = 1'b0;
        if (w_baud_tick) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_txd = r_shift[r_bit_idx];
        if (w_baud_tick && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_baud_tick) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Baud counter restarts at every bit boundary and is held at zero while idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      if ((r_state == S_IDLE) || w_baud_tick) r_baud_cnt <= '0;
      else                                     r_baud_cnt <= r_baud_cnt + CW'(1);
      if (r_state == S_IDLE)                      r_bit_idx <= 3'd0;
      else if ((r_state == S_DATA) && w_baud_tick) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_uart_accept) r_shift <= mem_wdata[7:0];
    end
  end

  assign mem_rdata    = r_rdata;
  assign LEDS         = r_leds;
  assign TXD          = w_txd;
  assign uart_busy    = (r_state != S_IDLE);
  assign o_uart_state = r_state;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256: RAM depth in 32-bit words; power of two.
REQ-002 Parameter BAUD_DIV, default 16: clk cycles per UART bit; minimum 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 mem_addr  input  32  byte address from the processor; bits [1:0] ignored.
REQ-006 mem_rstrb  input  1  read request, one cycle per access.
REQ-007 mem_rdata  output  32  read data, registered.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wmask  input  4  byte-lane write enables; any bit set means a write this cycle.
REQ-010 LEDS  output  5  LED register.
REQ-011 TXD  output  1  UART serial out, 8N1, idle high.
REQ-012 uart_busy  output  1  high while a UART frame is in flight.

Function
REQ-013 Address decode: mem_addr[22]=0 selects RAM; mem_addr[22]=1 selects IO; all other upper bits are ignored.
REQ-014 RAM word index is mem_addr[log2(RAM_WORDS)+1:2], so addresses beyond the RAM size wrap modulo RAM_WORDS.
REQ-015 Read latency is 1: mem_rstrb high at edge N loads mem_rdata at edge N; data is valid in cycle N+1.
REQ-016 mem_rdata holds its value until the next mem_rstrb.
REQ-017 RAM write: on each edge, every byte lane i with mem_wmask[i]=1 writes mem_wdata[8i+7:8i]; other lanes are unchanged.
REQ-018 Simultaneous mem_rstrb and write to the same RAM word: the read returns the pre-write value (read-before-write).
REQ-019 IO register map, selected by mem_addr[3:2]:
  - 0: LEDS (R/W).
  - 1: UART_DATA (W) / UART status (R).
  - 2: CYCLES (RO).
  - 3: reserved; reads 0, writes ignored.
REQ-020 LEDS write occurs when mem_wmask[0]=1: LEDS <= mem_wdata[4:0]. A read returns {27'b0, LEDS}.
REQ-021 UART_DATA write with mem_wmask[0]=1 while uart_busy=0 latches mem_wdata[7:0] and starts a frame; uart_busy goes high the next cycle.
REQ-022 UART_DATA write while uart_busy=1 is dropped silently; the in-flight frame is unaffected.
REQ-023 A UART status read returns {31'b0, uart_busy} as sampled at the strobe edge.
REQ-024 CYCLES is a 32-bit free-running counter: +1 every clk, wraps 0xFFFFFFFF -> 0. A read returns its value at the strobe edge.
REQ-025 UART FSM states and transitions:
  - IDLE -> START on an accepted write.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8 bits of BAUD_DIV cycles each, sent LSB first.
  - STOP -> IDLE after BAUD_DIV cycles.
REQ-026 TXD per state: 1 in IDLE and STOP, 0 in START, the current data bit in DATA.
REQ-027 uart_busy = (state != IDLE), so a frame occupies exactly 10*BAUD_DIV cycles of uart_busy=1.
REQ-028 A new frame is accepted on the first cycle after the FSM returns to IDLE.
REQ-029 IO writes never modify RAM; RAM writes never modify IO state.

Reset
REQ-030 While resetn=0 at an edge:
  - mem_rdata=0, LEDS=0, TXD=1, uart_busy=0, CYCLES=0, UART FSM=IDLE.
  - Reads and writes presented that cycle are ignored.
REQ-031 Reset mid-frame aborts the frame immediately: TXD=1 from the next cycle, no partial byte resumes.
REQ-032 RAM contents are not cleared by reset.
REQ-033 CYCLES reads 1 on a strobe issued in the first cycle after resetn rises.

Verification
REQ-034 Byte-lane write: write 0x11223344 mask 4'b1111 at addr 0x10, then 0xAABBCCDD mask 4'b0101 at 0x10, then read 0x10 -> 0x11BB33DD, valid one cycle after the strobe.
REQ-035 Wrap and read-before-write:
  - Write 0xDEADBEEF to addr 4*RAM_WORDS, then read addr 0 -> 0xDEADBEEF.
  - Same-cycle read+write of 0x12345678 to addr 0 -> mem_rdata=0xDEADBEEF; a later read -> 0x12345678.
REQ-036 LEDS: write 0xFFFFFFFF to 0x400000 -> LEDS=5'b11111; read 0x400000 -> 0x0000001F; write with mask 4'b1110 -> LEDS unchanged.
REQ-037 UART frame: BAUD_DIV=4, write 0xA5 to 0x400004 -> TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; uart_busy high for exactly 40 cycles. A second write of 0x3C issued mid-frame is dropped and the line returns to idle.
REQ-038 Reset mid-frame: assert resetn=0 during DATA bit 3 -> next cycle TXD=1, uart_busy=0, LEDS=0; RAM word at 0x10 still reads its pre-reset value.
REQ-039 CYCLES: strobes to 0x400008 issued 100 cycles apart return values differing by exactly 100; after a forced wrap from 0xFFFFFFFF the next read returns a small value.
